// File: rtl/dm_ctrl.sv
// Wait-state data memory controller: big-endian byte/half/word access with valid/ready handshakes.
// Optional macro DM_MISALIGN_EN makes misaligned half/word accesses legal.
module dm_ctrl #(
  parameter int MEM_BYTES = 128,
  parameter int LAT       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT       state, stateNext;
  logic [3:0]  waitCnt;
  logic        wrReg, unsReg;
  logic [1:0]  sizeReg;
  logic [31:0] addrReg, wdataReg;
  logic [7:0]  mem [MEM_BYTES];

  logic          accessEdge;
  logic [2:0]    nBytes;
  logic [32:0]   endAddr;
  logic          outOfRange, misaligned, accErr;
  logic [AW-1:0] baseIdx;
  logic [7:0]    rdByte [4];
  logic [31:0]   loadData, storeWord;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // The access happens on the edge leaving WAIT with the counter at zero,
  // giving LAT+1 cycles from accept to rsp_valid (LAT=0 spends one cycle in WAIT).
  assign accessEdge = (state == WAIT) && (waitCnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req_valid) stateNext = WAIT;
      WAIT:    if (waitCnt == 4'd0) stateNext = RESP;
      RESP:    if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt  <= '0;
      wrReg    <= 1'b0;
      sizeReg  <= '0;
      unsReg   <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
    end else if (state == IDLE && req_valid) begin
      waitCnt  <= 4'(LAT);
      wrReg    <= req_write;
      sizeReg  <= req_size;
      unsReg   <= req_unsigned;
      addrReg  <= req_addr;
      wdataReg <= req_wdata;
    end else if (state == WAIT && waitCnt != 4'd0) begin
      waitCnt <= waitCnt - 4'd1;
    end
  end

  always_comb begin
    case (sizeReg)
      2'd0:    nBytes = 3'd1;
      2'd1:    nBytes = 3'd2;
      default: nBytes = 3'd4;
    endcase
  end

  assign endAddr    = {1'b0, addrReg} + {30'b0, nBytes} - 33'd1;
  assign outOfRange = (endAddr >= 33'(MEM_BYTES));

`ifdef DM_MISALIGN_EN
  assign misaligned = 1'b0;
`else
  assign misaligned = ((sizeReg == 2'd1) && addrReg[0]) ||
                      ((sizeReg == 2'd2) && (addrReg[1:0] != 2'b00));
`endif

  assign accErr  = (sizeReg == 2'd3) || misaligned || outOfRange;
  assign baseIdx = addrReg[AW-1:0];

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      rdByte[k] = mem[baseIdx + AW'(k)];
    end
  end

  always_comb begin
    loadData = '0;
    case (sizeReg)
      2'd0:    loadData = {{24{rdByte[0][7] & ~unsReg}}, rdByte[0]};
      2'd1:    loadData = {{16{rdByte[0][7] & ~unsReg}}, rdByte[0], rdByte[1]};
      default: loadData = {rdByte[0], rdByte[1], rdByte[2], rdByte[3]};
    endcase
  end

  // Narrow store data is left-justified so byte k always comes from bits [31-8k -: 8].
  always_comb begin
    case (sizeReg)
      2'd0:    storeWord = {wdataReg[7:0], 24'b0};
      2'd1:    storeWord = {wdataReg[15:0], 16'b0};
      default: storeWord = wdataReg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accessEdge && wrReg && !accErr) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (k < {29'b0, nBytes}) mem[baseIdx + AW'(k)] <= storeWord[31 - 8*k -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accessEdge) begin
      rsp_err   <= accErr;
      rsp_rdata <= (accErr || wrReg) ? '0 : loadData;
    end else if (state == RESP && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: a LAT=2 and a LAT=0 instance share stimulus, selected by sel.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqWrite, reqUnsigned, rspReady;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        sel;

  logic        rrA, rvA, eA, rr0, rv0, e0;
  logic [31:0] rdA, rd0;
  logic        reqReadyM, rspValidM, rspErrM;
  logic [31:0] rspRdataM;

  always #5 clk = ~clk;

  dm_ctrl #(.MEM_BYTES(128), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid & ~sel), .req_ready(rrA),
    .req_write(reqWrite), .req_size(reqSize), .req_unsigned(reqUnsigned),
    .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rvA),
    .rsp_ready(rspReady), .rsp_rdata(rdA), .rsp_err(eA)
  );

  dm_ctrl #(.MEM_BYTES(128), .LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(reqValid & sel), .req_ready(rr0),
    .req_write(reqWrite), .req_size(reqSize), .req_unsigned(reqUnsigned),
    .req_addr(reqAddr), .req_wdata(reqWdata), .rsp_valid(rv0),
    .rsp_ready(rspReady), .rsp_rdata(rd0), .rsp_err(e0)
  );

  assign reqReadyM = sel ? rr0 : rrA;
  assign rspValidM = sel ? rv0 : rvA;
  assign rspRdataM = sel ? rd0 : rdA;
  assign rspErrM   = sel ? e0  : eA;

  int unsigned passCnt = 0;
  int unsigned totalCnt = 0;
  logic [7:0]  refMem [2][128];
  logic [32:0] expQ [$];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic doReq(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
    int          idx, nb, n;
    logic        err;
    logic [31:0] v, held;
    logic [32:0] e;
    idx = sel ? 1 : 0;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (({1'b0, a} + 33'(nb) - 33'd1) >= 33'd128);
`ifndef DM_MISALIGN_EN
    err = err || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`endif
    v = '0;
    if (!err) begin
      if (w) begin
        for (int k = 0; k < nb; k++) refMem[idx][int'(a[6:0]) + k] = wd[8*(nb-1-k) +: 8];
      end else begin
        for (int k = 0; k < nb; k++) v = {v[23:0], refMem[idx][int'(a[6:0]) + k]};
        if (nb == 1 && !uns && v[7])  v[31:8]  = '1;
        if (nb == 2 && !uns && v[15]) v[31:16] = '1;
      end
    end
    expQ.push_back({err, v});

    @(negedge clk);
    reqWrite = w; reqSize = sz; reqUnsigned = uns; reqAddr = a; reqWdata = wd;
    reqValid = 1'b1; rspReady = 1'b0;
    n = 0;
    while (!reqReadyM && n < 20) begin @(negedge clk); n++; end
    checkVal("acceptWait", 32'(n), 32'd0);
    if (!reqReadyM) begin
      reqValid = 1'b0;
      void'(expQ.pop_back());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0; reqAddr = $urandom; reqWdata = $urandom; reqSize = 2'($urandom);
    checkVal("busyReady", {31'b0, reqReadyM}, 32'd0);
    n = 0;
    while (!rspValidM && n < 40) begin @(negedge clk); n++; end
    checkVal("latency", 32'(n), sel ? 32'd1 : 32'd3);
    held = rspRdataM;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      checkVal("holdValid", {31'b0, rspValidM}, 32'd1);
      checkVal("holdData", rspRdataM, held);
      checkVal("holdReady", {31'b0, reqReadyM}, 32'd0);
    end
    e = expQ.pop_front();
    checkVal($sformatf("rdata@%h", a), rspRdataM, e[31:0]);
    checkVal($sformatf("err@%h", a), {31'b0, rspErrM}, {31'b0, e[32]});
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkVal("idleReady", {31'b0, reqReadyM}, 32'd1);
    checkVal("idleValid", {31'b0, rspValidM}, 32'd0);
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, "Ready"}, {31'b0, reqReadyM}, 32'd1);
    checkVal({tag, "Valid"}, {31'b0, rspValidM}, 32'd0);
    checkVal({tag, "Rdata"}, rspRdataM, 32'd0);
    checkVal({tag, "Err"}, {31'b0, rspErrM}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) for (int j = 0; j < 128; j++) refMem[i][j] = '0;
    rst_n = 1'b0; sel = 1'b0; reqValid = 1'b0; rspReady = 1'b0;
    reqWrite = 1'b0; reqSize = '0; reqUnsigned = 1'b0; reqAddr = '0; reqWdata = '0;
    #12;
    checkReset("rstA");
    sel = 1'b1; #1;
    checkReset("rst0");
    sel = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Fill both memories so every later load has a known model value.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int a = 0; a < 128; a += 4) doReq(1'b1, 2'd2, 1'b0, 32'(a), $urandom, 0);
    end
    sel = 1'b0;

    doReq(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0);
    doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    doReq(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0);
    doReq(1'b1, 2'd0, 1'b0, 32'h12, 32'h00000080, 0);
    doReq(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 0);
    doReq(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 0);
    doReq(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000BEEF, 0);
    doReq(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 0);
    doReq(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 0);
    doReq(1'b0, 2'd2, 1'b1, 32'h20, 32'h0, 0);
    doReq(1'b1, 2'd2, 1'b0, 32'h7E, 32'hA5A5A5A5, 0);
    doReq(1'b0, 2'd2, 1'b0, 32'h7C, 32'h0, 0);
    doReq(1'b0, 2'd0, 1'b0, 32'h80, 32'h0, 0);
    doReq(1'b0, 2'd0, 1'b0, 32'h7F, 32'h0, 0);
    doReq(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0);
    doReq(1'b1, 2'd1, 1'b0, 32'h21, 32'h00001234, 0);
    doReq(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
    doReq(1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 0);
    doReq(1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0, 0);
    doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
    doReq(1'b1, 2'd2, 1'b0, 32'h44, 32'h55667788, 0);
    doReq(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 0);

    // Reset during the wait phase of a store: the store must be dropped.
    @(negedge clk);
    reqWrite = 1'b1; reqSize = 2'd2; reqUnsigned = 1'b0; reqAddr = 32'h40; reqWdata = 32'hDEADBEEF;
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkReset("midRst");
    @(negedge clk); rst_n = 1'b1;
    doReq(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);

    for (int i = 0; i < 30; i++) begin
      doReq(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            32'($urandom_range(0, 131)), $urandom, (i % 7 == 0) ? 2 : 0);
    end

    sel = 1'b1;
    doReq(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, 0);
    doReq(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0);
    doReq(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 0);
    doReq(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, 3);
    doReq(1'b0, 2'd2, 1'b0, 32'h7E, 32'h0, 0);
    for (int i = 0; i < 15; i++) begin
      doReq(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
            32'($urandom_range(0, 131)), $urandom, 0);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
